pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage D/E/M/W pipeline registers. Each cycle it decodes the register-use information of the D-stage and E-stage instructions and drives the stall, stall_E and per-stage Clr controls of the pipeline registers. It also owns the multi-cycle multiply/divide busy sequencer, which blocks HI/LO consumers and back-to-back mult/div issue, and it keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the D/E/M/W pipeline registers.
//   It detects load-use, mult/div (HI/LO) and, optionally, branch-operand
//   hazards. It drives the stall / stall_E / Clr controls combinationally.
//   It owns the multi-cycle mult/div busy sequencer and keeps a saturating
//   stall-cycle counter.
//
//   Optional feature macro: PIPE_HAZARD_BRANCH_STALL_EN
//     defined   : a branch in D waits for E-stage ALU results and M-stage loads
//     undefined : brHaz = 0; branchD, rdM and memReadM are ignored
//
// Ports
//   Clk, Rst_n           clock (rising edge), async active-low reset
//   rsD, rtD             D-stage source registers
//   usesRsD, usesRtD     D-stage instruction reads rs / rt
//   branchD              D-stage instruction compares operands in D
//   mdUseD               D-stage instruction reads HI/LO or is a mult/div
//   rdE                  E-stage destination register
//   regWriteE, memReadE  E-stage writes a register / is a load
//   mdStartE, mdDivE     E-stage is a mult/div; 1 = divide, 0 = multiply
//   rdM, memReadM        M-stage destination register / is a load
//   flushD, flushE       external flush requests
//   stall                freeze PC and D, bubble into E
//   stall_E              freeze PC, D and E
//   ClrD..ClrW           pipeline-register clears
//   pcEn                 PC write enable
//   mdBusy               mult/div unit busy
//   stallCnt             saturating count of stalled cycles
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             usesRsD,
  input  logic             usesRtD,
  input  logic             branchD,
  input  logic             mdUseD,
  input  logic [4:0]       rdE,
  input  logic             regWriteE,
  input  logic             memReadE,
  input  logic             mdStartE,
  input  logic             mdDivE,
  input  logic [4:0]       rdM,
  input  logic             memReadM,
  input  logic             flushD,
  input  logic             flushE,
  output logic             stall,
  output logic             stall_E,
  output logic             ClrD,
  output logic             ClrE,
  output logic             ClrM,
  output logic             ClrW,
  output logic             pcEn,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic md_haz_d;
  logic md_haz_e;
  logic br_haz;
  logic stall_raw;
  logic stall_e_raw;

  assign mdBusy = (state_q == BUSY);

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign load_use = memReadE && (rdE != 5'd0) &&
                    ((usesRsD && (rsD == rdE)) || (usesRtD && (rtD == rdE)));

  assign md_haz_d = mdUseD && (mdBusy || mdStartE);
  assign md_haz_e = mdStartE && mdBusy;

`ifdef PIPE_HAZARD_BRANCH_STALL_EN
  logic src_match_e;
  logic src_match_m;

  assign src_match_e = (usesRsD && (rsD == rdE)) || (usesRtD && (rtD == rdE));
  assign src_match_m = (usesRsD && (rsD == rdM)) || (usesRtD && (rtD == rdM));
  assign br_haz = branchD &&
                  ((regWriteE && (rdE != 5'd0) && src_match_e) ||
                   (memReadM  && (rdM != 5'd0) && src_match_m));
`else
  logic unused_branch_inputs;

  assign unused_branch_inputs = ^{branchD, rdM, memReadM, regWriteE};
  assign br_haz = 1'b0;
`endif

  assign stall_raw   = load_use || md_haz_d || br_haz;
  assign stall_e_raw = md_haz_e;

  // While reset is held every register is cleared and the PC is frozen.
  // The pipeline registers already gate Clr against stall themselves.
  always_comb begin
    stall    = Rst_n && stall_raw;
    stall_E  = Rst_n && stall_e_raw;
    pcEn     = Rst_n && !(stall_raw || stall_e_raw);
    ClrD     = !Rst_n || flushD;
    ClrE     = !Rst_n || flushE;
    ClrM     = !Rst_n || stall_e_raw;
    ClrW     = !Rst_n;
    stallCnt = stall_cnt_q;
  end

  // A mdStartE held while BUSY is taken on the first IDLE cycle. flushE does
  // not abort BUSY because the HI/LO write still completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mdStartE) begin
          cnt_d   = mdDivE ? DIV_LOAD : MULT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_raw || stall_e_raw) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. The stimulus process drives one
// directed vector per cycle and pushes the hand-derived expected outputs;
// the monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic [4:0]    rsD, rtD, rdE, rdM;
  logic          usesRsD, usesRtD, branchD, mdUseD;
  logic          regWriteE, memReadE, mdStartE, mdDivE, memReadM;
  logic          flushD, flushE;
  logic          stall, stall_E, ClrD, ClrE, ClrM, ClrW, pcEn, mdBusy;
  logic [CW-1:0] stallCnt;

  pipe_hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (CW)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .rsD      (rsD),
    .rtD      (rtD),
    .usesRsD  (usesRsD),
    .usesRtD  (usesRtD),
    .branchD  (branchD),
    .mdUseD   (mdUseD),
    .rdE      (rdE),
    .regWriteE(regWriteE),
    .memReadE (memReadE),
    .mdStartE (mdStartE),
    .mdDivE   (mdDivE),
    .rdM      (rdM),
    .memReadM (memReadM),
    .flushD   (flushD),
    .flushE   (flushE),
    .stall    (stall),
    .stall_E  (stall_E),
    .ClrD     (ClrD),
    .ClrE     (ClrE),
    .ClrM     (ClrM),
    .ClrW     (ClrW),
    .pcEn     (pcEn),
    .mdBusy   (mdBusy),
    .stallCnt (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packing: {stall, stall_E, ClrD, ClrE, ClrM, ClrW, pcEn, mdBusy, stallCnt}
  logic [8+CW-1:0] exp_q[$];
  string           name_q[$];
  int              checks   = 0;
  int              failures = 0;
  int              sc       = 0;  // expected stallCnt before the current edge
  bit              stim_done = 0;

`ifdef PIPE_HAZARD_BRANCH_STALL_EN
  localparam logic BR_ON = 1'b1;
`else
  localparam logic BR_ON = 1'b0;
`endif

  task automatic clear_inputs();
    rst_n = 1'b1; rsD = 5'd0; rtD = 5'd0; rdE = 5'd0; rdM = 5'd0;
    usesRsD = 1'b0; usesRtD = 1'b0; branchD = 1'b0; mdUseD = 1'b0;
    regWriteE = 1'b0; memReadE = 1'b0; mdStartE = 1'b0; mdDivE = 1'b0;
    memReadM = 1'b0; flushD = 1'b0; flushE = 1'b0;
  endtask

  // Push the expectation for the vector currently driven, then advance one cycle.
  task automatic tick(input string nm, input logic st, input logic se,
                      input logic cd, input logic ce, input logic cm,
                      input logic cw, input logic pc, input logic busy);
    if (!rst_n) sc = 0;
    exp_q.push_back({st, se, cd, ce, cm, cw, pc, busy, CW'(sc)});
    name_q.push_back(nm);
    if (rst_n && (st || se) && sc < (1 << CW) - 1) sc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents on each falling edge.
  initial begin
    logic [8+CW-1:0] got, exp;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {stall, stall_E, ClrD, ClrE, ClrM, ClrW, pcEn, mdBusy, stallCnt};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: got st/se/cD/cE/cM/cW/pc/busy=%b cnt=%0d, required %b cnt=%0d",
                   nm, got[8+CW-1:CW], got[CW-1:0], exp[8+CW-1:CW], exp[CW-1:0]);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset state
    rst_n = 1'b0; tick("reset0", 0,0, 1,1,1,1, 0,0);
    rst_n = 1'b0; tick("reset1", 0,0, 1,1,1,1, 0,0);
    clear_inputs(); tick("idle_after_reset", 0,0, 0,0,0,0, 1,0);

    // Load-use on rs, then no hazard
    clear_inputs(); memReadE = 1; rdE = 5'd8; usesRsD = 1; rsD = 5'd8;
    tick("loaduse_rs", 1,0, 0,0,0,0, 0,0);
    clear_inputs(); tick("loaduse_released", 0,0, 0,0,0,0, 1,0);
    clear_inputs(); memReadE = 1; rdE = 5'd0; usesRsD = 1; rsD = 5'd0;
    tick("loaduse_rd0", 0,0, 0,0,0,0, 1,0);
    clear_inputs(); memReadE = 1; rdE = 5'd9; usesRtD = 1; rtD = 5'd9; rsD = 5'd9;
    tick("loaduse_rt", 1,0, 0,0,0,0, 0,0);
    clear_inputs(); memReadE = 1; rdE = 5'd9; rsD = 5'd9;
    tick("loaduse_unqualified", 0,0, 0,0,0,0, 1,0);
    clear_inputs(); regWriteE = 1; rdE = 5'd9; usesRsD = 1; rsD = 5'd9;
    tick("alu_result_no_stall", 0,0, 0,0,0,0, 1,0);

    // Flushes pass straight through
    clear_inputs(); flushD = 1; flushE = 1;
    tick("flush", 0,0, 1,1,0,0, 1,0);

    // Mult then mflo: 5 busy cycles
    clear_inputs(); mdStartE = 1; mdDivE = 0;
    tick("mult_issue", 0,0, 0,0,0,0, 1,0);
    clear_inputs(); mdUseD = 1; memReadE = 1; rdE = 5'd8; usesRsD = 1; rsD = 5'd8;
    tick("mflo_and_loaduse", 1,0, 0,0,0,0, 0,1);
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); mdUseD = 1;
      tick("mflo_wait", 1,0, 0,0,0,0, 0,1);
    end
    clear_inputs(); mdUseD = 1;
    tick("mflo_go", 0,0, 0,0,0,0, 1,0);

    // Reset in the middle of BUSY drops the pending operation
    clear_inputs(); mdStartE = 1;
    tick("mult2_issue", 0,0, 0,0,0,0, 1,0);
    clear_inputs(); tick("mult2_busy", 0,0, 0,0,0,0, 1,1);
    clear_inputs(); rst_n = 1'b0;
    tick("reset_mid_busy", 0,0, 1,1,1,1, 0,0);
    clear_inputs(); tick("after_mid_reset", 0,0, 0,0,0,0, 1,0);

    // Back-to-back div: second held in E for 10 cycles, then a fresh 10-cycle BUSY
    clear_inputs(); mdStartE = 1; mdDivE = 1;
    tick("div_issue", 0,0, 0,0,0,0, 1,0);
    for (int i = 0; i < 10; i++) begin
      clear_inputs(); mdStartE = 1; mdDivE = 1; flushE = (i == 3);
      tick("div2_held", 0,1, 0,(i == 3),1,0, 0,1);
    end
    clear_inputs(); mdStartE = 1; mdDivE = 1;
    tick("div2_accept", 0,0, 0,0,0,0, 1,0);
    for (int i = 0; i < 10; i++) begin
      clear_inputs(); tick("div2_busy", 0,0, 0,0,0,0, 1,1);
    end
    clear_inputs(); tick("div2_done", 0,0, 0,0,0,0, 1,0);

    // mdUseD alongside a mult entering E stalls even while IDLE
    clear_inputs(); mdStartE = 1; mdUseD = 1;
    tick("md_start_and_use", 1,0, 0,0,0,0, 0,0);
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); tick("mult3_busy", 0,0, 0,0,0,0, 1,1);
    end
    clear_inputs(); tick("mult3_done", 0,0, 0,0,0,0, 1,0);

    // Branch hazards (depend on the build macro)
    clear_inputs(); branchD = 1; usesRsD = 1; rsD = 5'd3; regWriteE = 1; rdE = 5'd3;
    tick("branch_vs_E", BR_ON,0, 0,0,0,0, !BR_ON,0);
    clear_inputs(); branchD = 1; usesRtD = 1; rtD = 5'd4; memReadM = 1; rdM = 5'd4;
    tick("branch_vs_Mload", BR_ON,0, 0,0,0,0, !BR_ON,0);
    clear_inputs(); branchD = 1; usesRsD = 1; rsD = 5'd0; regWriteE = 1; rdE = 5'd0;
    tick("branch_r0", 0,0, 0,0,0,0, 1,0);

    // Saturation: 20 cycles of load-use, counter stops at 15
    for (int i = 0; i < 20; i++) begin
      clear_inputs(); memReadE = 1; rdE = 5'd8; usesRsD = 1; rsD = 5'd8;
      tick("saturate", 1,0, 0,0,0,0, 0,0);
    end
    clear_inputs(); tick("saturated_hold", 0,0, 0,0,0,0, 1,0);

    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: stimulus not finished, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule
